// File: rtl/pe_packet_injector.sv
// Round-robin packetizer: four typed PE sources into a 2-entry FIFO toward the NoC router port.
// Optional per-type pop counters (stat_*) when PE_PACKET_INJECTOR_STATS_EN is defined.
module pe_packet_injector #(
    parameter logic [3:0]  SOURCE_ADDRESS = 4'h0,
    parameter int unsigned IFMAP_LENGTH   = 25,
    parameter int unsigned FILTER_LENGTH  = 40,
    parameter int unsigned RESIDUE_LENGTH = 13,
    parameter int unsigned PSUM_LENGTH    = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ifmap_valid,
    output logic                      ifmap_ready,
    input  logic [IFMAP_LENGTH-1:0]   ifmap_data,
    input  logic [3:0]                ifmap_dest,
    input  logic                      filter_valid,
    output logic                      filter_ready,
    input  logic [FILTER_LENGTH-1:0]  filter_data,
    input  logic [3:0]                filter_dest,
    input  logic                      residue_valid,
    output logic                      residue_ready,
    input  logic [RESIDUE_LENGTH-1:0] residue_data,
    input  logic [3:0]                residue_dest,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    input  logic [PSUM_LENGTH-1:0]    psum_data,
    input  logic [3:0]                psum_dest,
`ifdef PE_PACKET_INJECTOR_STATS_EN
    output logic [15:0]               stat_ifmap,
    output logic [15:0]               stat_filter,
    output logic [15:0]               stat_residue,
    output logic [15:0]               stat_psum,
`endif
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [63:0]               pkt_data
);
    localparam int unsigned PAYLOAD_W = 54;

    logic [1:0]  count_q;
    logic [1:0]  rr_q;
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [63:0] buf_q [2];

    logic [3:0]  valid_vec;
    logic [3:0]  grant_vec;
    logic        grant_any;
    logic [1:0]  grant_idx;
    logic [1:0]  scan_idx;
    logic [63:0] push_pkt;
    logic        push;
    logic        pop;

    assign valid_vec = {psum_valid, residue_valid, filter_valid, ifmap_valid};

    // Grant depends only on valids, rr and count, never on pkt_ready.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_q;
        scan_idx  = rr_q;
        if (rst_n && count_q != 2'd2) begin
            for (int i = 0; i < 4; i++) begin
                scan_idx = rr_q + 2'(i);
                if (!grant_any && valid_vec[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    assign grant_vec     = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    assign ifmap_ready   = grant_vec[0];
    assign filter_ready  = grant_vec[1];
    assign residue_ready = grant_vec[2];
    assign psum_ready    = grant_vec[3];

    always_comb begin
        push_pkt = '0;
        unique case (grant_idx)
            2'd0: push_pkt = {ifmap_dest, SOURCE_ADDRESS, 2'b00, PAYLOAD_W'(ifmap_data)};
            2'd1: push_pkt = {filter_dest, SOURCE_ADDRESS, 2'b01, PAYLOAD_W'(filter_data)};
            2'd2: push_pkt = {residue_dest, SOURCE_ADDRESS, 2'b10, PAYLOAD_W'(residue_data)};
            2'd3: push_pkt = {psum_dest, SOURCE_ADDRESS, 2'b11, PAYLOAD_W'(psum_data)};
            default: push_pkt = '0;
        endcase
    end

    assign pkt_valid = (count_q != 2'd0);
    assign pkt_data  = buf_q[rd_ptr_q];
    assign pop       = pkt_valid & pkt_ready;
    assign push      = grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rr_q     <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= push_pkt;
                wr_ptr_q        <= ~wr_ptr_q;
                rr_q            <= grant_idx + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef PE_PACKET_INJECTOR_STATS_EN
    logic [15:0] stat_q [4];

    // Counters are indexed by the type field of the packet leaving the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                stat_q[i] <= 16'd0;
            end
        end else if (pop && stat_q[pkt_data[55:54]] != 16'hFFFF) begin
            stat_q[pkt_data[55:54]] <= stat_q[pkt_data[55:54]] + 16'd1;
        end
    end

    assign stat_ifmap   = stat_q[0];
    assign stat_filter  = stat_q[1];
    assign stat_residue = stat_q[2];
    assign stat_psum    = stat_q[3];
`endif

endmodule

// File: tb/tb_pe_packet_injector.sv
// Bench for pe_packet_injector: table vectors, scoreboard of expected packets, corner sequences.
module tb_pe_packet_injector;
    logic        clk;
    logic        rst_n;
    logic        ifmap_valid, ifmap_ready;
    logic [24:0] ifmap_data;
    logic [3:0]  ifmap_dest;
    logic        filter_valid, filter_ready;
    logic [39:0] filter_data;
    logic [3:0]  filter_dest;
    logic        residue_valid, residue_ready;
    logic [12:0] residue_data;
    logic [3:0]  residue_dest;
    logic        psum_valid, psum_ready;
    logic [12:0] psum_data;
    logic [3:0]  psum_dest;
    logic        pkt_valid, pkt_ready;
    logic [63:0] pkt_data;
`ifdef PE_PACKET_INJECTOR_STATS_EN
    logic [15:0] stat_ifmap, stat_filter, stat_residue, stat_psum;
`endif

    pe_packet_injector #(
        .SOURCE_ADDRESS(4'h5),
        .IFMAP_LENGTH  (25),
        .FILTER_LENGTH (40),
        .RESIDUE_LENGTH(13),
        .PSUM_LENGTH   (13)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifmap_valid  (ifmap_valid),
        .ifmap_ready  (ifmap_ready),
        .ifmap_data   (ifmap_data),
        .ifmap_dest   (ifmap_dest),
        .filter_valid (filter_valid),
        .filter_ready (filter_ready),
        .filter_data  (filter_data),
        .filter_dest  (filter_dest),
        .residue_valid(residue_valid),
        .residue_ready(residue_ready),
        .residue_data (residue_data),
        .residue_dest (residue_dest),
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .psum_data    (psum_data),
        .psum_dest    (psum_dest),
`ifdef PE_PACKET_INJECTOR_STATS_EN
        .stat_ifmap   (stat_ifmap),
        .stat_filter  (stat_filter),
        .stat_residue (stat_residue),
        .stat_psum    (stat_psum),
`endif
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_data     (pkt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scoreboard of expected packets plus round-robin pointer.
    logic [63:0] exp_q[$];
    logic [63:0] pop_log[$];
    int          acc_log[$];
    int          m_rr = 0;
    int          m_g;
    logic [3:0]  m_vld, m_rdy, m_exp_rdy;
    bit          mon_en = 1'b0;

    function automatic logic [63:0] fmt(int g);
        case (g)
            0:       return {ifmap_dest, 4'h5, 2'b00, 29'd0, ifmap_data};
            1:       return {filter_dest, 4'h5, 2'b01, 14'd0, filter_data};
            2:       return {residue_dest, 4'h5, 2'b10, 41'd0, residue_data};
            default: return {psum_dest, 4'h5, 2'b11, 41'd0, psum_data};
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            m_vld     = {psum_valid, residue_valid, filter_valid, ifmap_valid};
            m_rdy     = {psum_ready, residue_ready, filter_ready, ifmap_ready};
            m_exp_rdy = 4'b0000;
            m_g       = -1;
            if (!rst_n) begin
                exp_q.delete();
                m_rr = 0;
                check("rst_ready", 64'(m_rdy), 64'h0);
                check("rst_pkt_valid", 64'(pkt_valid), 64'h0);
                check("rst_pkt_data", pkt_data, 64'h0);
            end else begin
                if (exp_q.size() < 2) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_g < 0 && m_vld[(m_rr + k) % 4]) m_g = (m_rr + k) % 4;
                    end
                end
                if (m_g >= 0) m_exp_rdy[m_g] = 1'b1;
                check("ready", 64'(m_rdy), 64'(m_exp_rdy));
                check("pkt_valid", 64'(pkt_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) check("pkt_data", pkt_data, exp_q[0]);
                if (pkt_valid && pkt_ready) pop_log.push_back(pkt_data);
                if (pkt_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (m_g >= 0) begin
                    exp_q.push_back(fmt(m_g));
                    acc_log.push_back(m_g);
                    m_rr = (m_g + 1) % 4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(int ch, logic v, logic [39:0] d, logic [3:0] dest);
        case (ch)
            0: begin ifmap_valid = v; ifmap_data = d[24:0]; ifmap_dest = dest; end
            1: begin filter_valid = v; filter_data = d; filter_dest = dest; end
            2: begin residue_valid = v; residue_data = d[12:0]; residue_dest = dest; end
            default: begin psum_valid = v; psum_data = d[12:0]; psum_dest = dest; end
        endcase
    endtask

    function automatic logic rdy_of(int ch);
        case (ch)
            0:       return ifmap_ready;
            1:       return filter_ready;
            2:       return residue_ready;
            default: return psum_ready;
        endcase
    endfunction

    int last_wait;

    // Source-side driver: holds valid/data until accepted, bounded wait.
    task automatic send(int ch, logic [39:0] d, logic [3:0] dest);
        logic acc = 1'b0;
        int   n   = 0;
        set_src(ch, 1'b1, d, dest);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rdy_of(ch);
            n++;
            tick();
        end
        set_src(ch, 1'b0, d, dest);
        last_wait = n;
        check("send_accepted", 64'(acc), 64'h1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rr = 0;
    endtask

    typedef struct {
        int          ch;
        logic [39:0] data;
        logic [3:0]  dest;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 40'h00_001A_BCDE, 4'h3, 64'h3500_0000_001A_BCDE};
        vecs[1] = '{1, 40'hFF_FFFF_FFFF, 4'hA, 64'hA540_00FF_FFFF_FFFF};
        vecs[2] = '{2, 40'h00_0000_1FFF, 4'hF, 64'hF580_0000_0000_1FFF};
        vecs[3] = '{3, 40'h00_0000_0ABC, 4'h0, 64'h05C0_0000_0000_0ABC};
        vecs[4] = '{1, 40'h12_3456_789A, 4'h7, 64'h7540_0012_3456_789A};

        rst_n = 1'b0;
        pkt_ready = 1'b0;
        set_src(0, 1'b1, 40'h11, 4'h1);
        set_src(1, 1'b1, 40'h22, 4'h2);
        set_src(2, 1'b1, 40'h33, 4'h4);
        set_src(3, 1'b1, 40'h44, 4'h8);
        mon_en = 1'b1;

        // Reset held with all sources valid, then release into continuous fairness traffic.
        repeat (3) tick();
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        acc_log.delete();
        @(negedge clk);
        check("first_ifmap_ready", 64'(ifmap_ready), 64'h1);
        repeat (9) tick();
        for (int c = 0; c < 4; c++) set_src(c, 1'b0, 40'h0, 4'h0);
        check("fair_count", 64'(acc_log.size() >= 8), 64'h1);
        for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
            check("fair_order", 64'(acc_log[i]), 64'(i % 4));
        end
        repeat (4) tick();

        // Table vectors: one packet at a time through an empty buffer.
        for (int i = 0; i < 5; i++) begin
            set_src(vecs[i].ch, 1'b1, vecs[i].data, vecs[i].dest);
            tick();
            set_src(vecs[i].ch, 1'b0, vecs[i].data, vecs[i].dest);
            @(negedge clk);
            check("vec_pkt_valid", 64'(pkt_valid), 64'h1);
            check("vec_pkt_data", pkt_data, vecs[i].exp);
            tick();
            @(negedge clk);
            check("vec_empty_after", 64'(pkt_valid), 64'h0);
            tick();
        end

        // Backpressure: two psum packets fill the buffer, third stalls until a pop.
        pkt_ready = 1'b0;
        send(3, 40'h1, 4'h2);
        send(3, 40'h2, 4'h2);
        set_src(3, 1'b1, 40'h3, 4'h2);
        repeat (3) begin
            @(negedge clk);
            check("bp_psum_stall", 64'(psum_ready), 64'h0);
        end
        tick();
        pop_log.delete();
        pkt_ready = 1'b1;
        send(3, 40'h3, 4'h2);
        check("bp_third_after_pop", 64'(last_wait), 64'd2);
        repeat (4) tick();
        check("bp_pop_count", 64'(pop_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
            check("bp_pop_order", 64'(pop_log[i][12:0]), 64'(i + 1));
        end

        // Mid-operation reset with two packets buffered and rr advanced.
        pkt_ready = 1'b0;
        send(0, 40'h0AAA, 4'h1);
        send(1, 40'h0BBB, 4'h2);
        set_src(0, 1'b1, 40'h0CCC, 4'h3);
        set_src(1, 1'b1, 40'h0DDD, 4'h4);
        rst_n = 1'b0;
        #1;
        check("midrst_pkt_valid", 64'(pkt_valid), 64'h0);
        check("midrst_pkt_data", pkt_data, 64'h0);
        check("midrst_ready", 64'({psum_ready, residue_ready, filter_ready, ifmap_ready}), 64'h0);
        #1;
        rst_n = 1'b1;
        model_reset();
        pop_log.delete();
        pkt_ready = 1'b1;
        set_src(2, 1'b1, 40'h0EEE, 4'h5);
        set_src(3, 1'b1, 40'h0FFF, 4'h6);
        @(negedge clk);
        check("midrst_rr_zero", 64'(ifmap_ready), 64'h1);
        check("midrst_no_stale", 64'(pkt_valid), 64'h0);
        tick();
        for (int c = 0; c < 4; c++) set_src(c, 1'b0, 40'h0, 4'h0);
        repeat (3) tick();
        check("midrst_pop_count", 64'(pop_log.size()), 64'd1);

`ifdef PE_PACKET_INJECTOR_STATS_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        pkt_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(1, 40'(i), 4'h1);
        for (int i = 0; i < 2; i++) send(2, 40'(i), 4'h2);
        repeat (4) tick();
        check("stat_ifmap", 64'(stat_ifmap), 64'd0);
        check("stat_filter", 64'(stat_filter), 64'd3);
        check("stat_residue", 64'(stat_residue), 64'd2);
        check("stat_psum", 64'(stat_psum), 64'd0);
        set_src(0, 1'b1, 40'h7, 4'h9);
        repeat (65540) tick();
        set_src(0, 1'b0, 40'h7, 4'h9);
        repeat (4) tick();
        check("stat_ifmap_sat", 64'(stat_ifmap), 64'hFFFF);
        check("stat_filter_hold", 64'(stat_filter), 64'd3);
`endif

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_packet_injector.md
Name: pe_packet_injector

Overview:
- Clocked transmit-side counterpart of the PE depacketizer. Builds the 64-bit NoC packets that the depacketizer consumes.
- Four typed source channels feed it: ifmap, filter, residue and partial sum.
- It round-robin arbitrates among the sources, formats each packet, and buffers up to two packets toward the router port.
- Sits at the PE/NoC boundary on the injection side of every convolution and partial-sum PE.

Parameters:
- SOURCE_ADDRESS, 4'h0, value placed in packet source field [59:56].
- IFMAP_LENGTH, 25, ifmap payload width (type 2'b00).
- FILTER_LENGTH, 40, filter payload width (type 2'b01).
- RESIDUE_LENGTH, 13, residue payload width (type 2'b10).
- PSUM_LENGTH, 13, partial-sum payload width (type 2'b11).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ifmap_valid / ifmap_ready  in / out  1 / 1  ifmap source handshake.
- ifmap_data  in  IFMAP_LENGTH  ifmap payload.
- ifmap_dest  in  4  destination address for the ifmap packet.
- filter_valid / filter_ready / filter_data / filter_dest  in / out / in / in  1 / 1 / FILTER_LENGTH / 4  filter source.
- residue_valid / residue_ready / residue_data / residue_dest  in / out / in / in  1 / 1 / RESIDUE_LENGTH / 4  residue source.
- psum_valid / psum_ready / psum_data / psum_dest  in / out / in / in  1 / 1 / PSUM_LENGTH / 4  partial-sum source.
- pkt_valid  out  1  packet available at head of output buffer.
- pkt_ready  in  1  router accepts the packet.
- pkt_data  out  64  formatted packet.

Behaviour:
- Handshakes: all channels are valid/ready. A transfer occurs on a rising edge with valid & ready both high.
  - Sources hold valid and data stable until accepted.
  - pkt_data and pkt_valid stay stable while pkt_valid & !pkt_ready.
- Packet format: {dest[3:0], SOURCE_ADDRESS[3:0], type[1:0], payload zero-extended to 54 bits}. Type codes: ifmap 00, filter 01, residue 10, psum 11.
- Output buffer: 2-entry FIFO with 2-bit occupancy count (0..2), read pointer and write pointer.
  - pkt_valid = (count != 0); pkt_data = head entry.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Arbitration:
  - At most one source is accepted per cycle.
  - A grant is possible only when count < 2. There is no combinational path from pkt_ready to any *_ready.
  - Round-robin priority pointer rr (2 bits) selects the first valid source starting at index rr, order ifmap(0), filter(1), residue(2), psum(3).
  - After a grant to index g, rr <= g+1 mod 4. With no grant, rr holds.
- *_ready:
  - Asserted only for the granted source, combinationally from the valids, rr and count.
  - The granted ready may be high only while that source's valid is high.
  - All *_ready are 0 when count == 2 or rst_n == 0.
- Latency: a packet accepted at edge N shows pkt_valid = 1 after edge N (visible in cycle N+1) if the buffer was empty. Throughput is one packet per cycle with pkt_ready held high.
- Full: count == 2 and pkt_ready = 0 → all *_ready = 0; sources stall, nothing is dropped.
- Full with pop: count == 2 and pkt_ready = 1 → pop only; pushes resume the following cycle.
- Empty: pkt_valid = 0; pkt_data holds the last head value, don't-care.
- Reset:
  - rst_n low → immediately pkt_valid = 0, pkt_data = 0, all *_ready = 0, count = 0, pointers = 0, rr = 0.
  - Buffered packets are discarded on reset, including a mid-transfer reset.
  - First edge after deassertion: arbitration is live.

Optional Feature:
- Macro: PE_PACKET_INJECTOR_STATS_EN.
- When defined, adds outputs stat_ifmap, stat_filter, stat_residue and stat_psum, each 16 bits.
  - Each counts packets of that type popped at the output (pkt_valid & pkt_ready).
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with all valids high → pkt_valid = 0, pkt_data = 64'h0, all ready = 0. Release → ifmap_ready = 1 in the first cycle (rr = 0).
- Single packet: SOURCE_ADDRESS = 4'h5, ifmap_data = 25'h1ABCDE, ifmap_dest = 4'h3, pkt_ready = 1 → next cycle pkt_valid = 1, pkt_data = 64'h3500_0000_001A_BCDE. Then pkt_valid = 0.
- Fairness: all four valid continuously, pkt_ready = 1 → accepted order ifmap, filter, residue, psum, ifmap..., one per cycle. pkt_data[55:54] cycles 00, 01, 10, 11.
- Backpressure: pkt_ready = 0, psum sends 13'h0001, 13'h0002, 13'h0003 → first two accepted, then psum_ready = 0 while count == 2. Raise pkt_ready → packets emerge with payloads 1, 2, 3 in order; third accepted after the first pop.
- Reset mid-operation: two packets buffered, pulse rst_n low between edges → pkt_valid drops immediately. After release, no stale packet is emitted and rr = 0.
- Stats (macro defined): 3 filter and 2 residue packets popped → stat_filter = 3, stat_residue = 2, others 0. Preload near 16'hFFFF via a long stream → the counter holds 16'hFFFF.
